// File: rtl/uart_tx_arbiter.sv
// Two-hart UART transmit arbiter: per-hart byte FIFOs drained round-robin
// into one registered valid/ready byte stream.

module uart_tx_arbiter_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr,
    input  logic [7:0] data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = wr && !full;
    assign head  = mem[rptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            // a push while full is dropped even if a pop frees a slot this edge
            if (wr && full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= data;
    end
endmodule

module uart_tx_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       a_wr,
    input  logic [7:0] a_data,
    output logic       a_full,
    output logic       a_ovf,
    input  logic       b_wr,
    input  logic [7:0] b_data,
    output logic       b_full,
    output logic       b_ovf,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    input  logic       uart_ready,
    output logic       uart_src,
    output logic       idle
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] a_head;
    logic [7:0] b_head;
    logic       a_empty;
    logic       b_empty;
    logic       last_b;
    logic       load;
    logic       grant_b;
    logic       a_pop;
    logic       b_pop;

    uart_tx_arbiter_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_a (
        .clk(clk), .resetn(resetn), .wr(a_wr), .data(a_data), .pop(a_pop),
        .head(a_head), .full(a_full), .empty(a_empty), .ovf(a_ovf)
    );

    uart_tx_arbiter_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_b (
        .clk(clk), .resetn(resetn), .wr(b_wr), .data(b_data), .pop(b_pop),
        .head(b_head), .full(b_full), .empty(b_empty), .ovf(b_ovf)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        // B wins when A is empty, or on contention when A was granted last
        grant_b    = !b_empty && (a_empty || !last_b);
        if ((state == IDLE || uart_ready) && !(a_empty && b_empty)) begin
            load       = 1'b1;
            next_state = BUSY;
        end else if (state == BUSY && uart_ready) begin
            next_state = IDLE;
        end
    end

    assign a_pop = load && !grant_b;
    assign b_pop = load && grant_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_data <= '0;
            uart_src  <= 1'b0;
            last_b    <= 1'b1;
        end else if (load) begin
            uart_data <= grant_b ? b_head : a_head;
            uart_src  <= grant_b;
            last_b    <= grant_b;
        end
    end

    assign uart_valid = (state == BUSY);
    assign idle       = (state == IDLE) && a_empty && b_empty;
endmodule
